// File: rtl/rew_phase_sequencer.sv
// rtl/rew_phase_sequencer.sv - REW access-phase sequencer with programmable RO:RW ratio.
// Optional REW_SEQ_STATS_EN adds saturating RO/RW access completion counters.
module rew_phase_sequencer #(
  parameter int RW_R_CHUNK = 8,
  parameter int RW_W_CHUNK = 8,
  parameter int RO_R_CHUNK = 4,
  parameter int RO_W_CHUNK = 4,
  parameter int EW         = 8,
  parameter int E_DEFAULT  = 5,
  localparam int MAX_RW    = (RW_R_CHUNK > RW_W_CHUNK) ? RW_R_CHUNK : RW_W_CHUNK,
  localparam int MAX_RO    = (RO_R_CHUNK > RO_W_CHUNK) ? RO_R_CHUNK : RO_W_CHUNK,
  localparam int MAX_CHUNK = (MAX_RW > MAX_RO) ? MAX_RW : MAX_RO,
  localparam int CW        = ($clog2(MAX_CHUNK) < 1) ? 1 : $clog2(MAX_CHUNK)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  input  logic          CfgValid,
  input  logic [EW-1:0] CfgE,
  input  logic          Transfer,
  output logic [CW-1:0] ChunkCtr,
  output logic          ROAccess,
  output logic          RWAccess,
  output logic          Read,
  output logic          Writeback,
  output logic          Idle,
  output logic          PhaseDone,
  output logic          AccessDone,
  output logic [EW-1:0] ROCount
`ifdef REW_SEQ_STATS_EN
  ,
  output logic [31:0]   RWAccessCount,
  output logic [31:0]   ROAccessCount
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_RO_R, S_RO_W, S_RW_R, S_RW_W} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_ctr, w_ctr_nxt, w_last_idx;
  logic [EW-1:0] r_e, w_e_nxt, r_rocount, w_rocount_nxt, w_e_start;
  logic [EW:0]   w_ro_inc;
  logic          w_last, w_access_done;

  always_comb begin
    w_last_idx = '0;
    case (r_state)
      S_RO_R:  w_last_idx = CW'(RO_R_CHUNK - 1);
      S_RO_W:  w_last_idx = CW'(RO_W_CHUNK - 1);
      S_RW_R:  w_last_idx = CW'(RW_R_CHUNK - 1);
      S_RW_W:  w_last_idx = CW'(RW_W_CHUNK - 1);
      default: w_last_idx = '0;
    endcase
  end

  assign w_last        = (r_state != S_IDLE) && Transfer && (r_ctr == w_last_idx);
  assign w_access_done = w_last && ((r_state == S_RO_W) || (r_state == S_RW_W));
  // EW+1 bits so ROCount+1 cannot wrap when E is at its maximum
  assign w_ro_inc      = {1'b0, r_rocount} + {{EW{1'b0}}, 1'b1};
  assign w_e_start     = CfgValid ? CfgE : r_e;

  always_comb begin
    w_state_nxt   = r_state;
    w_ctr_nxt     = r_ctr;
    w_e_nxt       = r_e;
    w_rocount_nxt = r_rocount;
    case (r_state)
      S_IDLE: begin
        if (CfgValid) w_e_nxt = CfgE;
        if (Start) begin
          // An RW access is owed when E is zero or a halt left the RO quota met
          if ((w_e_start != '0) && (r_rocount < w_e_start)) begin
            w_state_nxt = S_RO_R;
          end else begin
            w_state_nxt   = S_RW_R;
            w_rocount_nxt = '0;
          end
        end
      end
      S_RO_R: if (w_last) w_state_nxt = S_RO_W;
      S_RW_R: if (w_last) w_state_nxt = S_RW_W;
      S_RO_W: begin
        if (w_last) begin
          if (w_ro_inc >= {1'b0, r_e}) begin
            w_state_nxt   = S_RW_R;
            w_rocount_nxt = '0;
          end else begin
            w_state_nxt   = S_RO_R;
            w_rocount_nxt = w_ro_inc[EW-1:0];
          end
        end
      end
      S_RW_W: begin
        if (w_last) begin
          w_state_nxt   = (r_e == '0) ? S_RW_R : S_RO_R;
          w_rocount_nxt = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if ((r_state != S_IDLE) && Transfer) w_ctr_nxt = w_last ? '0 : r_ctr + 1'b1;
    if (w_access_done && Halt) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_ctr     <= '0;
      r_e       <= EW'(E_DEFAULT);
      r_rocount <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ctr     <= w_ctr_nxt;
      r_e       <= w_e_nxt;
      r_rocount <= w_rocount_nxt;
    end
  end

  // Phase flags are forced to their idle values while Reset is held
  assign ChunkCtr   = r_ctr;
  assign ROCount    = r_rocount;
  assign Idle       = Reset || (r_state == S_IDLE);
  assign ROAccess   = !Reset && ((r_state == S_RO_R) || (r_state == S_RO_W));
  assign RWAccess   = !Reset && ((r_state == S_RW_R) || (r_state == S_RW_W));
  assign Read       = !Reset && ((r_state == S_RO_R) || (r_state == S_RW_R));
  assign Writeback  = !Reset && ((r_state == S_RO_W) || (r_state == S_RW_W));
  assign PhaseDone  = !Reset && w_last;
  assign AccessDone = !Reset && w_access_done;

`ifdef REW_SEQ_STATS_EN
  logic [31:0] r_rw_acc_cnt, r_ro_acc_cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rw_acc_cnt <= '0;
      r_ro_acc_cnt <= '0;
    end else if (w_access_done) begin
      if ((r_state == S_RW_W) && (r_rw_acc_cnt != '1)) r_rw_acc_cnt <= r_rw_acc_cnt + 32'd1;
      if ((r_state == S_RO_W) && (r_ro_acc_cnt != '1)) r_ro_acc_cnt <= r_ro_acc_cnt + 32'd1;
    end
  end

  assign RWAccessCount = r_rw_acc_cnt;
  assign ROAccessCount = r_ro_acc_cnt;
`endif

endmodule

// File: tb/tb_rew_phase_sequencer.sv
// tb/tb_rew_phase_sequencer.sv - self-checking bench for rew_phase_sequencer.
module tb_rew_phase_sequencer;
  localparam logic [2:0] P_IDLE = 3'd0, P_ROR = 3'd1, P_ROW = 3'd2, P_RWR = 3'd3, P_RWW = 3'd4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0, Halt = 1'b0, CfgValid = 1'b0, Transfer = 1'b0;
  logic [7:0] CfgE = 8'd0;
  logic [2:0] ChunkCtr;
  logic       ROAccess, RWAccess, Read, Writeback, Idle, PhaseDone, AccessDone;
  logic [7:0] ROCount;
`ifdef REW_SEQ_STATS_EN
  logic [31:0] RWAccessCount, ROAccessCount;
`endif

  rew_phase_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Halt(Halt), .CfgValid(CfgValid),
    .CfgE(CfgE), .Transfer(Transfer), .ChunkCtr(ChunkCtr), .ROAccess(ROAccess),
    .RWAccess(RWAccess), .Read(Read), .Writeback(Writeback), .Idle(Idle),
    .PhaseDone(PhaseDone), .AccessDone(AccessDone), .ROCount(ROCount)
`ifdef REW_SEQ_STATS_EN
    , .RWAccessCount(RWAccessCount), .ROAccessCount(ROAccessCount)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       rst, st, hl, cv;
    logic [7:0] ce;
    logic       xf;
    logic [2:0] ph, ctr;
    logic       pd, ad;
    logic [7:0] roc;
  } vec_t;

  vec_t        tbl[7];
  logic [17:0] sb[$];
  int total = 0, bad = 0;
  int pd_seen = 0, ad_seen = 0, ro_seen = 0;

  function automatic logic [17:0] expv(logic [2:0] ph, logic [2:0] ctr, logic pd, logic ad, logic [7:0] roc);
    return {ph == P_IDLE, (ph == P_ROR) || (ph == P_ROW), (ph == P_RWR) || (ph == P_RWW),
            (ph == P_ROR) || (ph == P_RWR), (ph == P_ROW) || (ph == P_RWW), pd, ad, ctr, roc};
  endfunction

  task automatic check(input logic [31:0] act, input logic [31:0] exp, input string name);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, st, hl, cv, input logic [7:0] ce, input logic xf);
    @(negedge Clock);
    Reset = rst; Start = st; Halt = hl; CfgValid = cv; CfgE = ce; Transfer = xf;
  endtask

  task automatic step(input logic rst, st, hl, cv, input logic [7:0] ce, input logic xf,
                      input logic [2:0] ph, ctr, input logic pd, ad, input logic [7:0] roc,
                      input string name);
    logic [17:0] act;
    drive(rst, st, hl, cv, ce, xf);
    sb.push_back(expv(ph, ctr, pd, ad, roc));
    #1;
    act = {Idle, ROAccess, RWAccess, Read, Writeback, PhaseDone, AccessDone, ChunkCtr, ROCount};
    if (PhaseDone) pd_seen++;
    if (AccessDone) ad_seen++;
    if (ROAccess) ro_seen++;
    check(32'(act), 32'(sb.pop_front()), name);
  endtask

  task automatic run_phase(input logic [2:0] ph, input int n, input logic [7:0] roc,
                           input logic hl, input string name);
    for (int k = 0; k < n; k++)
      step(1'b0, 1'b0, hl, 1'b0, 8'd0, 1'b1, ph, 3'(k), k == n - 1,
           (k == n - 1) && ((ph == P_ROW) || (ph == P_RWW)), roc, $sformatf("%s_%0d", name, k));
  endtask

  task automatic gapped_phase(input logic [2:0] ph, input int n, input logic [7:0] roc, input string name);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 1'b0, (k == 1) && (ph == P_ROR), 8'd1, 1'b0, ph, 3'(k), 1'b0, 1'b0, roc,
           $sformatf("%s_gap_a%0d", name, k));
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, ph, 3'(k), 1'b0, 1'b0, roc, $sformatf("%s_gap_b%0d", name, k));
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, ph, 3'(k), k == n - 1,
           (k == n - 1) && (ph == P_ROW), roc, $sformatf("%s_xfer%0d", name, k));
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd0, "reset_state");
  endtask

  initial begin
    // reset, ignored Transfer in IDLE, configure E=2, Start into RO_R and hold
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, P_ROR,  3'd0, 1'b0, 1'b0, 8'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, P_ROR,  3'd0, 1'b0, 1'b0, 8'd0};
    for (int i = 0; i < 7; i++)
      step(tbl[i].rst, tbl[i].st, tbl[i].hl, tbl[i].cv, tbl[i].ce, tbl[i].xf,
           tbl[i].ph, tbl[i].ctr, tbl[i].pd, tbl[i].ad, tbl[i].roc, $sformatf("table_%0d", i));

    // E=2: two RO accesses then one RW access
    pd_seen = 0;
    run_phase(P_ROR, 4, 8'd0, 1'b0, "e2_ror0");
    run_phase(P_ROW, 4, 8'd0, 1'b0, "e2_row0");
    run_phase(P_ROR, 4, 8'd1, 1'b0, "e2_ror1");
    run_phase(P_ROW, 4, 8'd1, 1'b0, "e2_row1");
    run_phase(P_RWR, 8, 8'd0, 1'b0, "e2_rwr");
    run_phase(P_RWW, 8, 8'd0, 1'b0, "e2_rww");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, P_ROR, 3'd0, 1'b0, 1'b0, 8'd0, "e2_back_ror");
    check(32'(pd_seen), 32'd6, "e2_phasedone_count");

    // E=0 loaded together with Start: RW only
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd0, "e0_cfg_start");
    ro_seen = 0; ad_seen = 0;
    run_phase(P_RWR, 8, 8'd0, 1'b0, "e0_rwr0");
    run_phase(P_RWW, 8, 8'd0, 1'b0, "e0_rww0");
    run_phase(P_RWR, 8, 8'd0, 1'b0, "e0_rwr1");
    run_phase(P_RWW, 8, 8'd0, 1'b0, "e0_rww1");
    check(32'(ro_seen), 32'd0, "e0_no_roaccess");
    check(32'(ad_seen), 32'd2, "e0_accessdone_count");

    // default E=5 with Halt held: stop after first RO writeback, resume RO_R
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd0, "halt_start");
    run_phase(P_ROR, 4, 8'd0, 1'b1, "halt_ror");
    run_phase(P_ROW, 4, 8'd0, 1'b1, "halt_row");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd1, "halt_idle");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd1, "halt_restart");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, P_ROR,  3'd0, 1'b0, 1'b0, 8'd1, "halt_resume_ror");

    // Reset mid RW_R at ChunkCtr=3 discards the access and restores E=5
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd0, "mid_cfg0");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd0, "mid_start");
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, P_RWR, 3'(k), 1'b0, 1'b0, 8'd0, $sformatf("mid_rwr_%0d", k));
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, P_RWR, 3'd3, 1'b0, 1'b0, 8'd0, "mid_rwr_ctr3");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    #1;
    check({28'd0, Idle, Read, RWAccess, PhaseDone}, {28'd0, 4'b1000}, "mid_during_reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd0, "mid_after_reset");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd0, "mid_restart");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, P_ROR,  3'd0, 1'b0, 1'b0, 8'd0, "mid_e5_ror");

    // gapped Transfer; CfgValid outside IDLE must not change E
    pd_seen = 0;
    gapped_phase(P_ROR, 4, 8'd0, "gap_ror");
    gapped_phase(P_ROW, 4, 8'd0, "gap_row");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, P_ROR, 3'd0, 1'b0, 1'b0, 8'd1, "gap_e_unchanged");
    check(32'(pd_seen), 32'd2, "gap_phasedone_count");

`ifdef REW_SEQ_STATS_EN
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd0, "st_cfg1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, P_IDLE, 3'd0, 1'b0, 1'b0, 8'd0, "st_start");
    for (int r = 0; r < 3; r++) begin
      run_phase(P_ROR, 4, 8'd0, 1'b0, $sformatf("st%0d_ror", r));
      run_phase(P_ROW, 4, 8'd0, 1'b0, $sformatf("st%0d_row", r));
      run_phase(P_RWR, 8, 8'd0, 1'b0, $sformatf("st%0d_rwr", r));
      run_phase(P_RWW, 8, 8'd0, 1'b0, $sformatf("st%0d_rww", r));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, P_ROR, 3'd0, 1'b0, 1'b0, 8'd0, "st_end");
    check(ROAccessCount, 32'd3, "stats_ro_count");
    check(RWAccessCount, 32'd3, "stats_rw_count");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
